approx_seq_mult: RTL and testbench
==================================

APPROX_SEQ_MULT -- requirements
Module: approx_seq_mult

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 The block SHALL provide parameter TRUNC, default 4, number of low product columns discarded in approximate mode (legal 0..WIDTH).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-007 Port: approx_en  input  1  1 = truncated partial products, 0 = exact; latched with operands.
REQ-008 Port: a  input  WIDTH  unsigned multiplicand.
REQ-009 Port: b  input  WIDTH  unsigned multiplier.
REQ-010 Port: busy  output  1  high while a multiply is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when product is updated.
REQ-012 Port: product  output  2*WIDTH  unsigned result, held until next completion.

Function
REQ-013 FSM SHALL have two states: IDLE and RUN.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL latch a, b, approx_en, clear the accumulator and bit counter to 0, and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE with all registers unchanged.
REQ-016 In RUN, each rising edge SHALL process multiplier bit i = counter: if b_reg[i]=1, add partial product PP_i = a_reg << i (zero-extended to 2*WIDTH) to the accumulator; then increment counter.
REQ-017 When approx_en_reg=1, PP_i bits at column positions < TRUNC SHALL be forced to 0 before addition; when approx_en_reg=0, PP_i SHALL be unmasked.
REQ-018 Accumulator SHALL be 2*WIDTH bits; no overflow is possible and no carry SHALL be dropped.
REQ-019 The edge that processes bit WIDTH-1 SHALL load product with the final accumulator value, set done=1, and return to IDLE.
REQ-020 Latency: start sampled at edge t -> done=1 and valid product visible after edge t+WIDTH, for exactly one cycle.
REQ-021 busy SHALL be 1 exactly while in RUN (registered, from edge t+1 to edge t+WIDTH).
REQ-022 start while busy=1 SHALL be ignored; operand or approx_en changes during RUN SHALL not affect the result.
REQ-023 start=1 in the cycle done=1 SHALL be accepted (back-to-back operation, no idle gap beyond the done cycle).
REQ-024 product SHALL change only on the completion edge; it SHALL hold its value in all other cycles.
REQ-025 b=0 or a=0 SHALL still take the full WIDTH cycles and yield product=0.
REQ-026 TRUNC=0 SHALL make approximate mode identical to exact mode.

Reset
REQ-027 rst=1 SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0, latched operands=0.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-029 Release of rst SHALL leave the block in IDLE; start on the first edge after release SHALL be accepted.

Verification (WIDTH=8, TRUNC=4)
REQ-030 Exact: a=255, b=255, approx_en=0, start pulse -> busy for 8 cycles, done pulse 8 edges after start, product=65025.
REQ-031 Approximate: a=255, b=255, approx_en=1 -> product=64976; a=15, b=15, approx_en=1 -> product=176 (exact 225).
REQ-032 Back-to-back: start held high across done cycle with a=3,b=5 then a=7,b=9, exact -> products 15 then 63, done pulses 9 cycles apart (8 RUN + done/accept cycle overlap per REQ-023), busy low only during the done cycle.
REQ-033 Ignore-while-busy: a=10,b=10 started, then start=1 with a=1,b=1 and approx_en toggled mid-RUN -> single done, product=100.
REQ-034 Reset mid-operation: rst pulsed at RUN cycle 4 -> busy, done, product all 0 immediately, no done pulse; subsequent a=12,b=12 exact -> product=144.
REQ-035 Zero/boundary: a=0,b=200 and a=200,b=0 -> product=0 after full 8-cycle latency; TRUNC=0 build with approx_en=1, a=255,b=255 -> product=65025.

Source files
------------

// File: rtl/approx_seq_mult.sv
// Sequential shift-and-add multiplier with an optional approximate mode.
// One multiplier bit is consumed per clock; in approximate mode the low
// TRUNC columns of every partial product are discarded before summation.
module approx_seq_mult #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 approx_en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2*WIDTH-1:0] TRUNC_MASK = {(2*WIDTH){1'b1}} << TRUNC;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               load;
    logic               step;
    logic               finish;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               approx_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      counter;

    logic [2*WIDTH-1:0] pp_shifted;
    logic [2*WIDTH-1:0] pp_masked;
    logic [2*WIDTH-1:0] acc_next;

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode: accept start only from IDLE, finish on the last bit.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (counter == LAST_BIT) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Partial product for the current multiplier bit, truncated in approximate mode.
    always_comb begin
        pp_shifted = {{WIDTH{1'b0}}, a_reg} << counter;
        pp_masked  = '0;
        if (b_reg[counter]) begin
            pp_masked = approx_reg ? (pp_shifted & TRUNC_MASK) : pp_shifted;
        end
        acc_next = acc + pp_masked;
    end

    // Datapath: latch operands on accept, accumulate each RUN cycle, publish on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            approx_reg <= 1'b0;
            acc        <= '0;
            counter    <= '0;
            product    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_reg      <= a;
                b_reg      <= b;
                approx_reg <= approx_en;
                acc        <= '0;
                counter    <= '0;
            end else if (step) begin
                acc     <= acc_next;
                counter <= counter + 1'b1;
                if (finish) begin
                    product <= acc_next;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_approx_seq_mult.sv
// Self-checking bench for approx_seq_mult: directed corner cases plus random
// operands, compared against an arithmetic model of truncated multiplication.
// A second instance built with TRUNC=0 shares every input.
module tb_approx_seq_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic        approx_en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        busy0;
    logic        done0;
    logic [15:0] product0;

    int total;
    int bad;
    logic [15:0] prev_product;
    logic [15:0] prev_product0;

    approx_seq_mult #(.WIDTH(8), .TRUNC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .approx_en (approx_en),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    approx_seq_mult #(.WIDTH(8), .TRUNC(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .approx_en (approx_en),
        .a         (a),
        .b         (b),
        .busy      (busy0),
        .done      (done0),
        .product   (product0)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: sum of a*2^i over set bits of b, each term rounded down to a multiple of 2^trunc when approximate.
    function automatic logic [15:0] model(input int unsigned av, input int unsigned bv,
                                          input bit ap, input int tr);
        longint acc;
        longint term;
        longint unit;
        acc  = 0;
        unit = longint'(1) << tr;
        for (int i = 0; i < 8; i++) begin
            if (((bv >> i) & 1) == 1) begin
                term = longint'(av) * (longint'(1) << i);
                if (ap) term = (term / unit) * unit;
                acc += term;
            end
        end
        return acc[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One multiply: start for one edge (or held if hold_start), disturb inputs mid-run, check every cycle.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input bit ap, input bit hold_start, input string tag);
        logic [15:0] expv;
        logic [15:0] expv0;
        expv  = model(av, bv, ap, 4);
        expv0 = model(av, bv, ap, 0);
        @(negedge clk);
        a = av; b = bv; approx_en = ap; start = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, ".busy_accept"}, busy, 1);
        checkOutput({tag, ".done_accept"}, done, 0);
        @(negedge clk);
        if (hold_start) begin
            a = 8'd1; b = 8'd1; approx_en = ~ap;
        end else begin
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom); approx_en = 1'($urandom);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k < 8) begin
                checkOutput({tag, ".busy_run"}, busy, 1);
                checkOutput({tag, ".done_run"}, done, 0);
                checkOutput({tag, ".hold"}, product, prev_product);
            end else begin
                checkOutput({tag, ".done"}, done, 1);
                checkOutput({tag, ".busy_done"}, busy, 0);
                checkOutput({tag, ".product"}, product, expv);
                checkOutput({tag, ".product_t0"}, product0, expv0);
            end
        end
        prev_product  = expv;
        prev_product0 = expv0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        bit         rap;
        total = 0;
        bad   = 0;
        prev_product  = '0;
        prev_product0 = '0;
        rst = 1'b1; start = 1'b0; approx_en = 1'b0; a = '0; b = '0;

        #12;
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.product", product, 0);
        @(negedge clk);
        rst = 1'b0;

        // Exact and approximate full-scale, small approximate case.
        applyStimulus(8'd255, 8'd255, 1'b0, 1'b0, "exact255");
        checkOutput("exact255.value", product, 65025);
        applyStimulus(8'd255, 8'd255, 1'b1, 1'b0, "approx255");
        checkOutput("approx255.value", product, 64976);
        checkOutput("trunc0.value", product0, 65025);
        applyStimulus(8'd15, 8'd15, 1'b1, 1'b0, "approx15");
        checkOutput("approx15.value", product, 176);

        // Start ignored while busy, operands and mode disturbed mid-run.
        applyStimulus(8'd10, 8'd10, 1'b0, 1'b1, "ignore");
        checkOutput("ignore.value", product, 100);
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("ignore.single_done", done, 0);
        checkOutput("ignore.idle", busy, 0);

        // Back-to-back with start held across the done cycle.
        applyStimulus(8'd3, 8'd5, 1'b0, 1'b1, "b2b_first");
        checkOutput("b2b_first.value", product, 15);
        applyStimulus(8'd7, 8'd9, 1'b0, 1'b1, "b2b_second");
        checkOutput("b2b_second.value", product, 63);
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2b.idle", busy, 0);

        // Reset mid-operation.
        @(negedge clk);
        a = 8'd50; b = 8'd60; approx_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst.busy", busy, 0);
        checkOutput("midrst.done", done, 0);
        checkOutput("midrst.product", product, 0);
        checkOutput("midrst.product_t0", product0, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checkOutput("midrst.no_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        prev_product  = '0;
        prev_product0 = '0;
        applyStimulus(8'd12, 8'd12, 1'b0, 1'b0, "after_rst");
        checkOutput("after_rst.value", product, 144);

        // Zero operands still take the full latency.
        applyStimulus(8'd0, 8'd200, 1'b0, 1'b0, "zero_a");
        applyStimulus(8'd200, 8'd0, 1'b1, 1'b0, "zero_b");

        // Random operands and modes.
        for (int n = 0; n < 24; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rap = 1'($urandom);
            applyStimulus(ra, rb, rap, 1'b0, "random");
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("final.done_clear", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
